nios2_ocimem_access_arbiter: RTL and testbench

Shares the single-port on-chip debug memory (OCI RAM) between the CPU-side Avalon debug slave and the JTAG debug path. Consumes the sysclk-domain ocimem strobes and the jdo bus to sequence JTAG reads and writes with an auto-incrementing address. Returns JTAG read data on MonDReg. Arbitrates CPU and JTAG accesses round-robin.

---
 rtl/nios2_ocimem_access_arbiter.sv | 179 +++++++++++++++++
 tb/tb_nios2_ocimem_access_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ocimem_access_arbiter.sv
// Shares the single-port OCI debug RAM between the CPU Avalon debug slave and
// the JTAG debug path. Grants are round-robin between the two sides.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   jdo, take_action_ocimem_a/b,
//   take_no_action_ocimem_a      JTAG strobes and payload (sysclk domain)
//   av_*                         CPU-side Avalon slave (read/write/stall/data)
//   ram_*                        RAM port (ram_rdata has 1-cycle latency)
//   MonDReg                      last JTAG read data
//   jtag_addr                    current auto-incrementing JTAG word address
//   jtag_pending                 JTAG operation queued or in flight
//   jtag_overrun                 sticky: a JTAG strobe was dropped
module nios2_ocimem_access_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] jtag_addr,
  output logic              jtag_pending,
  output logic              jtag_overrun
);

  localparam int unsigned ADDR_LSB = 17;
  localparam logic        GRANT_CPU  = 1'b0;
  localparam logic        GRANT_JTAG = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    JTAG_RD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              pending_q, pending_d;
  logic              is_write_q, is_write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mon_q, mon_d;
  logic              overrun_q, overrun_d;

  logic cpu_req;
  logic strobe;
  logic grant_cpu;
  logic grant_jtag;
  logic unused_jdo;

  assign cpu_req    = av_read | av_write;
  assign strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign MonDReg      = mon_q;
  assign jtag_addr    = addr_q;
  assign jtag_pending = pending_q;
  assign jtag_overrun = overrun_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_CPU;
      pending_q    <= 1'b0;
      is_write_q   <= 1'b0;
      wdata_q      <= '0;
      addr_q       <= '0;
      mon_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      is_write_q   <= is_write_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      mon_q        <= mon_d;
      overrun_q    <= overrun_d;
    end
  end

  // Arbitration, RAM steering, CPU handshake and JTAG strobe capture
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pending_d      = pending_q;
    is_write_d     = is_write_q;
    wdata_d        = wdata_q;
    addr_d         = addr_q;
    mon_d          = mon_q;
    overrun_d      = overrun_q;
    grant_cpu      = 1'b0;
    grant_jtag     = 1'b0;
    ram_addr       = av_address;
    ram_be         = av_byteenable;
    ram_wdata      = av_writedata;
    ram_we         = 1'b0;
    av_readdata    = '0;
    av_waitrequest = cpu_req;

    case (state_q)
      IDLE: begin
        // Grants are gated by reset_n so nothing completes while reset is held.
        if (reset_n) begin
          grant_jtag = pending_q && (!cpu_req || (last_grant_q == GRANT_CPU));
          grant_cpu  = cpu_req && !grant_jtag;
        end
        if (grant_jtag) begin
          last_grant_d = GRANT_JTAG;
          ram_addr     = addr_q;
          ram_be       = 4'hF;
          ram_wdata    = wdata_q;
          if (is_write_q) begin
            ram_we    = 1'b1;
            pending_d = 1'b0;
            addr_d    = ADDR_W'(addr_q + 1'b1);
          end else begin
            state_d = JTAG_RD;
          end
        end else if (grant_cpu) begin
          last_grant_d = GRANT_CPU;
          if (av_write) begin
            ram_we         = 1'b1;
            av_waitrequest = 1'b0;
          end else begin
            state_d = CPU_RD;
          end
        end
      end
      CPU_RD: begin
        av_readdata    = ram_rdata;
        av_waitrequest = 1'b0;
        state_d        = IDLE;
      end
      JTAG_RD: begin
        mon_d     = ram_rdata;
        pending_d = 1'b0;
        addr_d    = ADDR_W'(addr_q + 1'b1);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes look at the registered pending flag, so one landing on the
    // clearing edge is still treated as an overrun.
    if (strobe) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        addr_d    = jdo[ADDR_LSB+ADDR_W-1:ADDR_LSB];
        overrun_d = 1'b0;
      end else if (take_action_ocimem_b) begin
        wdata_d    = jdo[34:3];
        pending_d  = 1'b1;
        is_write_d = 1'b1;
      end else begin
        pending_d  = 1'b1;
        is_write_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios2_ocimem_access_arbiter.sv
module tb_nios2_ocimem_access_arbiter;

  localparam int unsigned ADDR_W = 8;

  logic              clk;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [31:0]       av_writedata;
  logic [3:0]        av_byteenable;
  logic [31:0]       av_readdata;
  logic              av_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] jtag_addr;
  logic              jtag_pending;
  logic              jtag_overrun;

  logic              preload;
  logic [31:0]       mem [256];

  int n_vec;
  int n_err;
  int cpu_done;
  int jtag_done;
  logic [ADDR_W-1:0] prev_addr;

  nios2_ocimem_access_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_addr                (ram_addr),
    .ram_we                  (ram_we),
    .ram_be                  (ram_be),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .jtag_addr               (jtag_addr),
    .jtag_pending            (jtag_pending),
    .jtag_overrun            (jtag_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read; preload fills mem[i] = A500_00ii
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a);
    return 38'(a) << 17;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return 38'(d) << 3;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    preload = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    av_address = '0;
    av_read = 1'b1;
    av_write = 1'b0;
    av_writedata = '0;
    av_byteenable = 4'hF;

    // 1: reset state, stall held while reset asserted
    #2;
    chk("rst_waitreq", 32'(av_waitrequest), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    tick();
    preload = 1'b0;
    tick();
    chk("rst_waitreq2", 32'(av_waitrequest), 32'd1);
    chk("rst_mon", MonDReg, 32'd0);
    chk("rst_addr", 32'(jtag_addr), 32'd0);
    chk("rst_pend", 32'(jtag_pending), 32'd0);
    chk("rst_ovr", 32'(jtag_overrun), 32'd0);
    av_read = 1'b0;
    reset_n = 1'b1;

    // 2: JTAG write then read back through MonDReg
    tick();
    take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h10);
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b1; jdo = jdo_data(32'hDEADBEEF);
    tick();
    take_action_ocimem_b = 1'b0;
    #1;
    chk("jw_we", 32'(ram_we), 32'd1);
    chk("jw_addr", 32'(ram_addr), 32'h10);
    chk("jw_be", 32'(ram_be), 32'hF);
    chk("jw_wdata", ram_wdata, 32'hDEADBEEF);
    tick();
    chk("jw_incr", 32'(jtag_addr), 32'h11);
    chk("jw_pend_clr", 32'(jtag_pending), 32'd0);
    chk("jw_we_off", 32'(ram_we), 32'd0);
    take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h10);
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    #1;
    chk("jr_we", 32'(ram_we), 32'd0);
    tick();
    tick();
    chk("jr_mon", MonDReg, 32'hDEADBEEF);
    chk("jr_addr", 32'(jtag_addr), 32'h11);
    chk("jr_pend", 32'(jtag_pending), 32'd0);

    // 3: tie after reset goes to JTAG first, CPU read follows
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h12345678);
    tick();
    take_action_ocimem_b = 1'b0;
    av_read = 1'b1; av_address = 8'h20;
    #1;
    chk("tie_waitreq", 32'(av_waitrequest), 32'd1);
    chk("tie_jtag_we", 32'(ram_we), 32'd1);
    chk("tie_jtag_addr", 32'(ram_addr), 32'h00);
    chk("tie_jtag_wdata", ram_wdata, 32'h12345678);
    tick();
    chk("cpu_grant_wait", 32'(av_waitrequest), 32'd1);
    chk("cpu_grant_addr", 32'(ram_addr), 32'h20);
    chk("cpu_grant_we", 32'(ram_we), 32'd0);
    chk("tie_jaddr", 32'(jtag_addr), 32'd1);
    tick();
    chk("cpu_rd_wait", 32'(av_waitrequest), 32'd0);
    chk("cpu_rd_data", av_readdata, 32'hA500_0020);
    tick();
    av_read = 1'b0;
    #1;
    chk("cpu_rd_zero", av_readdata, 32'd0);

    // 4: continuous CPU writes against repeated JTAG reads
    cpu_done = 0;
    jtag_done = 0;
    prev_addr = jtag_addr;
    av_write = 1'b1; av_address = 8'h40; av_byteenable = 4'hF;
    for (int c = 0; c < 20; c++) begin
      if (c != 0) tick();
      av_writedata = 32'hCAFE_0000 | 32'(c);
      take_no_action_ocimem_a = !jtag_pending;
      if (jtag_addr != prev_addr) jtag_done++;
      prev_addr = jtag_addr;
      #1;
      if (!av_waitrequest) cpu_done++;
    end
    tick();
    take_no_action_ocimem_a = 1'b0;
    av_write = 1'b0;
    repeat (3) tick();
    chk("rr_cpu_min", 32'(cpu_done >= 6), 32'd1);
    chk("rr_jtag_min", 32'(jtag_done >= 6), 32'd1);
    chk("rr_no_ovr", 32'(jtag_overrun), 32'd0);
    chk("rr_drained", 32'(jtag_pending), 32'd0);

    // 5: address wrap, overrun on a strobe while pending, cleared by ocimem_a
    take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'hFF);
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h0BADF00D);
    tick();
    jdo = jdo_data(32'h11111111);
    #1;
    chk("wrap_we", 32'(ram_we), 32'd1);
    chk("wrap_addr", 32'(ram_addr), 32'hFF);
    chk("wrap_wdata", ram_wdata, 32'h0BADF00D);
    tick();
    take_action_ocimem_b = 1'b0;
    #1;
    chk("wrap_to_zero", 32'(jtag_addr), 32'h00);
    chk("ovr_set", 32'(jtag_overrun), 32'd1);
    chk("ovr_dropped", 32'(jtag_pending), 32'd0);
    chk("ovr_no_we", 32'(ram_we), 32'd0);
    chk("wrap_mem", mem[255], 32'h0BADF00D);
    take_action_ocimem_a = 1'b1; jdo = jdo_addr(8'h05);
    tick();
    take_action_ocimem_a = 1'b0;
    chk("ovr_clr", 32'(jtag_overrun), 32'd0);
    chk("ovr_clr_addr", 32'(jtag_addr), 32'h05);

    // 6: reset during JTAG_RD abandons the read
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mon", MonDReg, 32'd0);
    chk("mid_rst_pend", 32'(jtag_pending), 32'd0);
    chk("mid_rst_addr", 32'(jtag_addr), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("post_rst_we", 32'(ram_we), 32'd0);
      tick();
    end
    chk("post_rst_mon", MonDReg, 32'd0);
    chk("post_rst_pend", 32'(jtag_pending), 32'd0);
    chk("post_rst_addr", 32'(jtag_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
